// File: rtl/matvec_ntt_acc.sv
// matvec_ntt_acc: NTT-domain matrix-vector product w_hat = A_hat o v_hat over Z_q, q = 8380417.
// Four coefficient lanes per 96-bit memory word, exact Barrett reduction of each 46-bit product,
// per-lane modular accumulators. Optional input range checking is enabled by defining the macro
// MATVEC_RANGE_CHECK_EN; without it err is tied low and no compare logic exists.
`timescale 1ns/1ps
module matvec_ntt_acc #(
  parameter int K            = 8,
  parameter int L            = 7,
  parameter int N            = 256,
  parameter int COEFF_WIDTH  = 24,
  parameter int WORD_LEN     = 96,
  parameter int ADDR_A_WIDTH = $clog2(K*L*N/4),
  parameter int ADDR_V_WIDTH = $clog2(L*N/4),
  parameter int ADDR_W_WIDTH = $clog2(K*N/4)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_A_WIDTH-1:0] addr_matA,
  input  logic [WORD_LEN-1:0]     dout_matA,
  output logic [ADDR_V_WIDTH-1:0] addr_vec,
  input  logic [WORD_LEN-1:0]     dout_vec,
  output logic                    we_w,
  output logic [ADDR_W_WIDTH-1:0] addr_w,
  output logic [WORD_LEN-1:0]     din_w,
  output logic                    err
);
  localparam int W      = N/4;
  localparam int KCW    = (K > 1) ? $clog2(K) : 1;
  localparam int LCW    = (L > 1) ? $clog2(L) : 1;
  localparam int WCW    = (W > 1) ? $clog2(W) : 1;
  // Tag stages: 1 = address out, 2 = read data, 3 = product, 4 = Barrett quotient, 5 = reduced product
  localparam int STAGES = 5;
  localparam logic [22:0] Q         = 23'd8380417;
  localparam logic [69:0] BARRETT_M = (70'd1 << 46) / 70'd8380417;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_reg, state_next;
  logic   issue, done_next, start_accept, last_issue, pipe_active;

  logic [KCW-1:0] k_reg;
  logic [LCW-1:0] l_reg;
  logic [WCW-1:0] w_reg;
  logic [ADDR_A_WIDTH-1:0] addr_a_reg, addr_a_calc;
  logic [ADDR_V_WIDTH-1:0] addr_v_reg, addr_v_calc;
  logic [ADDR_W_WIDTH-1:0] waddr_calc;

  logic [STAGES:1]         v_pipe_reg, first_pipe_reg, last_pipe_reg;
  logic [ADDR_W_WIDTH-1:0] waddr_pipe_reg [1:STAGES];

  logic                    acc_last_reg;
  logic [ADDR_W_WIDTH-1:0] acc_waddr_reg;
  logic [22:0]             acc_lane [4];

  logic                    we_w_reg, done_reg, err_reg;
  logic [ADDR_W_WIDTH-1:0] addr_w_reg;
  logic [WORD_LEN-1:0]     din_w_reg;
  logic                    dout_unused;

  assign start_accept = (state_reg == IDLE) && start;
  assign last_issue   = (l_reg == LCW'(L-1)) && (w_reg == WCW'(W-1)) && (k_reg == KCW'(K-1));
  assign pipe_active  = (|v_pipe_reg) | acc_last_reg;
  assign addr_a_calc  = ADDR_A_WIDTH'(32'(k_reg) * (L*W) + 32'(l_reg) * W + 32'(w_reg));
  assign addr_v_calc  = ADDR_V_WIDTH'(32'(l_reg) * W + 32'(w_reg));
  assign waddr_calc   = ADDR_W_WIDTH'(32'(k_reg) * W + 32'(w_reg));
  // Only the low 23 bits of each lane feed the datapath; the rest is observed by the range check.
  assign dout_unused  = ^{dout_matA, dout_vec};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and control decode
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        issue = 1'b1;
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: if (!pipe_active) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read counters (l innermost, then word, then k) and registered read addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg      <= '0;
      l_reg      <= '0;
      w_reg      <= '0;
      addr_a_reg <= '0;
      addr_v_reg <= '0;
    end else if (issue) begin
      addr_a_reg <= addr_a_calc;
      addr_v_reg <= addr_v_calc;
      if (l_reg == LCW'(L-1)) begin
        l_reg <= '0;
        if (w_reg == WCW'(W-1)) begin
          w_reg <= '0;
          k_reg <= (k_reg == KCW'(K-1)) ? '0 : k_reg + 1'b1;
        end else begin
          w_reg <= w_reg + 1'b1;
        end
      end else begin
        l_reg <= l_reg + 1'b1;
      end
    end else if (start_accept) begin
      k_reg <= '0;
      l_reg <= '0;
      w_reg <= '0;
    end
  end

  // Control tags travelling alongside the lane datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe_reg     <= '0;
      first_pipe_reg <= '0;
      last_pipe_reg  <= '0;
      for (int s = 1; s <= STAGES; s++) waddr_pipe_reg[s] <= '0;
    end else begin
      v_pipe_reg[1]     <= issue;
      first_pipe_reg[1] <= (l_reg == '0);
      last_pipe_reg[1]  <= (l_reg == LCW'(L-1));
      waddr_pipe_reg[1] <= waddr_calc;
      for (int s = 2; s <= STAGES; s++) begin
        v_pipe_reg[s]     <= v_pipe_reg[s-1];
        first_pipe_reg[s] <= first_pipe_reg[s-1];
        last_pipe_reg[s]  <= last_pipe_reg[s-1];
        waddr_pipe_reg[s] <= waddr_pipe_reg[s-1];
      end
    end
  end

`ifdef MATVEC_RANGE_CHECK_EN
  logic [3:0] lane_bad;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [22:0] a_c, v_c;
      logic [45:0] prod_reg, prod_q_reg;
      logic [23:0] qhat_reg;
      logic [69:0] pm;
      logic [24:0] r0, r1;
      logic [22:0] r2, red_reg, acc_reg, sum_mod;
      logic [23:0] sum;
      logic        lane_unused;

      assign a_c = dout_matA[gi*COEFF_WIDTH +: 23];
      assign v_c = dout_vec[gi*COEFF_WIDTH +: 23];
      // Barrett: qhat undershoots floor(x/q) by at most 2, so r0 < 3q and two subtracts finish it.
      assign pm  = 70'(prod_reg) * BARRETT_M;
      assign r0  = 25'(47'(prod_q_reg) - 47'(qhat_reg) * 47'(Q));
      assign r1  = (r0 >= 25'(Q)) ? r0 - 25'(Q) : r0;
      assign r2  = (r1 >= 25'(Q)) ? 23'(r1 - 25'(Q)) : r1[22:0];
      assign sum     = 24'(red_reg) + 24'(acc_reg);
      assign sum_mod = (sum >= 24'(Q)) ? 23'(sum - 24'(Q)) : sum[22:0];
      assign lane_unused  = ^pm[45:0];
      assign acc_lane[gi] = acc_reg;
`ifdef MATVEC_RANGE_CHECK_EN
      assign lane_bad[gi] = dout_matA[gi*COEFF_WIDTH + 23] | (a_c >= Q) |
                            dout_vec[gi*COEFF_WIDTH + 23]  | (v_c >= Q);
`endif

      // Multiply, Barrett quotient, final reduction, then load-or-accumulate modulo q
      always_ff @(posedge clk) begin
        if (rst) begin
          prod_reg   <= '0;
          prod_q_reg <= '0;
          qhat_reg   <= '0;
          red_reg    <= '0;
          acc_reg    <= '0;
        end else begin
          prod_reg   <= 46'(a_c) * 46'(v_c);
          prod_q_reg <= prod_reg;
          qhat_reg   <= pm[69:46];
          red_reg    <= r2;
          if (v_pipe_reg[STAGES])
            acc_reg <= first_pipe_reg[STAGES] ? red_reg : sum_mod;
        end
      end
    end
  endgenerate

  // Result write port: one write per (k, word), the cycle after the last l is accumulated
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_last_reg  <= 1'b0;
      acc_waddr_reg <= '0;
      we_w_reg      <= 1'b0;
      addr_w_reg    <= '0;
      din_w_reg     <= '0;
    end else begin
      acc_last_reg  <= v_pipe_reg[STAGES] & last_pipe_reg[STAGES];
      acc_waddr_reg <= waddr_pipe_reg[STAGES];
      we_w_reg      <= acc_last_reg;
      if (acc_last_reg) begin
        addr_w_reg <= acc_waddr_reg;
        for (int j = 0; j < 4; j++)
          din_w_reg[j*COEFF_WIDTH +: COEFF_WIDTH] <= COEFF_WIDTH'(acc_lane[j]);
      end
    end
  end

  // Completion pulse
  always_ff @(posedge clk) begin
    if (rst) done_reg <= 1'b0;
    else     done_reg <= done_next;
  end

`ifdef MATVEC_RANGE_CHECK_EN
  // Sticky range error, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (rst)                               err_reg <= 1'b0;
    else if (start_accept)                 err_reg <= 1'b0;
    else if (v_pipe_reg[2] && (|lane_bad)) err_reg <= 1'b1;
  end
`else
  assign err_reg = 1'b0;
`endif

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign addr_matA = addr_a_reg;
  assign addr_vec  = addr_v_reg;
  assign we_w      = we_w_reg;
  assign addr_w    = addr_w_reg;
  assign din_w     = din_w_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_matvec_ntt_acc.sv
// tb_matvec_ntt_acc: scoreboard bench for matvec_ntt_acc with a plain-arithmetic reference model.
// Define MATVEC_RANGE_CHECK_EN for both files to also exercise the range-error flag.
`timescale 1ns/1ps
module tb_matvec_ntt_acc;
  localparam int K       = 8;
  localparam int L       = 7;
  localparam int N       = 256;
  localparam int CW      = 24;
  localparam int WL      = 96;
  localparam int AW      = $clog2(K*L*N/4);
  localparam int VW      = $clog2(L*N/4);
  localparam int WW      = $clog2(K*N/4);
  localparam longint Q   = 8380417;
  localparam int WORDS   = N/4;
  localparam int NWRITES = K*WORDS;
  localparam int TOTAL   = K*WORDS*L;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, we_w, err;
  logic [AW-1:0] addr_matA;
  logic [VW-1:0] addr_vec;
  logic [WW-1:0] addr_w;
  logic [WL-1:0] dout_matA = '0;
  logic [WL-1:0] dout_vec = '0;
  logic [WL-1:0] din_w;

  logic [WL-1:0] mem_a [K*L*N/4];
  logic [WL-1:0] mem_v [L*N/4];
  int unsigned   a_c [K][L][N];
  int unsigned   v_c [L][N];

  typedef struct {
    logic [WW-1:0] addr;
    logic [WL-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int wr_cnt = 0;

  matvec_ntt_acc dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .addr_matA(addr_matA), .dout_matA(dout_matA),
    .addr_vec(addr_vec), .dout_vec(dout_vec),
    .we_w(we_w), .addr_w(addr_w), .din_w(din_w), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories
  always @(posedge clk) begin
    dout_matA <= mem_a[addr_matA];
    dout_vec  <= mem_v[addr_vec];
  end

  // Monitor: pop and compare on every result write, count done pulses
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (we_w) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h with empty scoreboard", addr_w, din_w);
      end else begin
        mon_e = exp_q.pop_front();
        if (addr_w !== mon_e.addr || din_w !== mon_e.data) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                   addr_w, din_w, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_le(input string name, input int got, input int limit);
    checks++;
    if (got > limit) begin
      errors++;
      $display("FAIL %s got=%0d limit=%0d", name, got, limit);
    end
  endtask

  // Coefficient sets: 0 all ones, 1 all q-1, 2 A=k+l+n / v=n+1, else random in [0,q-1]
  task automatic fill_job(input int mode);
    for (int k = 0; k < K; k++)
      for (int l = 0; l < L; l++)
        for (int n = 0; n < N; n++)
          case (mode)
            0:       a_c[k][l][n] = 1;
            1:       a_c[k][l][n] = int'(Q - 1);
            2:       a_c[k][l][n] = k + l + n;
            default: a_c[k][l][n] = $urandom_range(0, int'(Q - 1));
          endcase
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++)
        case (mode)
          0:       v_c[l][n] = 1;
          1:       v_c[l][n] = int'(Q - 1);
          2:       v_c[l][n] = n + 1;
          default: v_c[l][n] = $urandom_range(0, int'(Q - 1));
        endcase
  endtask

  // Pack coefficients into memory words and push the expected result stream
  task automatic pack_and_expect();
    exp_t e;
    longint acc;
    int idx, n;
    for (int k = 0; k < K; k++)
      for (int l = 0; l < L; l++)
        for (int nn = 0; nn < N; nn++) begin
          idx = k*L*N + l*N + nn;
          mem_a[idx/4][(idx%4)*CW +: CW] = CW'(a_c[k][l][nn]);
        end
    for (int l = 0; l < L; l++)
      for (int nn = 0; nn < N; nn++) begin
        idx = l*N + nn;
        mem_v[idx/4][(idx%4)*CW +: CW] = CW'(v_c[l][nn]);
      end
    for (int k = 0; k < K; k++)
      for (int wd = 0; wd < WORDS; wd++) begin
        e.addr = WW'(k*WORDS + wd);
        e.data = '0;
        for (int j = 0; j < 4; j++) begin
          n = wd*4 + j;
          acc = 0;
          for (int l = 0; l < L; l++)
            acc = (acc + longint'(a_c[k][l][n]) * longint'(v_c[l][n])) % Q;
          e.data[j*CW +: CW] = CW'(acc);
        end
        exp_q.push_back(e);
      end
  endtask

  // Start a job, optionally pulse start again while busy, and wait (bounded) for done
  task automatic run_job(input string name, input int second_start_at, input logic exp_err);
    int m;
    done_cnt = 0;
    wr_cnt   = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 0;
    check({name, "_busy_after_start"}, busy, 1);
    check({name, "_err_after_start"}, err, 0);
    while (!done && m < TOTAL + 50) begin
      @(negedge clk);
      m++;
      start = (m == second_start_at);
    end
    start = 1'b0;
    check({name, "_done_seen"}, done, 1);
    check_le({name, "_cycles_to_done"}, m, TOTAL + 9);
    check({name, "_err_at_done"}, err, exp_err);
    repeat (3) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt, 1);
    check({name, "_write_count"}, wr_cnt, NWRITES);
    check({name, "_scoreboard_empty"}, exp_q.size(), 0);
    check({name, "_idle_after_done"}, busy, 0);
    $display("job %s: %0d cycles to done, %0d writes, %0d done pulses, err=%0b",
             name, m, wr_cnt, done_cnt, err);
  endtask

  initial begin
    for (int i = 0; i < K*L*N/4; i++) mem_a[i] = '0;
    for (int i = 0; i < L*N/4; i++)   mem_v[i] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we_w", we_w, 0);
    check("rst_err", err, 0);
    check("rst_addr_matA", addr_matA, 0);
    check("rst_addr_vec", addr_vec, 0);
    check("rst_addr_w", addr_w, 0);
    check("rst_din_w", din_w, 0);
    rst = 1'b0;
    @(negedge clk);

    fill_job(0); pack_and_expect(); run_job("ones", 0, 1'b0);
    fill_job(1); pack_and_expect(); run_job("q_minus_1", 0, 1'b0);
    fill_job(2); pack_and_expect(); run_job("pattern", 0, 1'b0);
    fill_job(3); pack_and_expect(); run_job("restart_ignored", 500, 1'b0);

    // Abort mid-run: no write the next cycle, no done, no late writes
    fill_job(3); pack_and_expect();
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    check("abort_we_w", we_w, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    wr_cnt = 0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_write", wr_cnt, 0);
    $display("job abort: reset after 100 run cycles, %0d writes and %0d done pulses afterwards",
             wr_cnt, done_cnt);

    fill_job(3); pack_and_expect(); run_job("after_abort", 0, 1'b0);

`ifdef MATVEC_RANGE_CHECK_EN
    fill_job(3);
    a_c[2][3][5] = int'(Q);
    pack_and_expect();
    run_job("range_err", 0, 1'b1);
    fill_job(0); pack_and_expect(); run_job("range_clear", 0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a bounded wait is ever defeated
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
